// File: rtl/riscv_femto_pkg.sv
// Shared types and encodings for the riscv_femto multi-cycle RV32I core.
package riscv_femto_pkg;

  typedef enum logic [2:0] {
    StFetchInstr,
    StWaitInstr,
    StFetchRegs,
    StExecute,
    StLoad,
    StWaitData,
    StStore,
    StHalt
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpAluReg = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Slt  = 3'b010;
  localparam logic [2:0] F3Sltu = 3'b011;
  localparam logic [2:0] F3Xor  = 3'b100;
  localparam logic [2:0] F3Sr   = 3'b101;
  localparam logic [2:0] F3Or   = 3'b110;
  localparam logic [2:0] F3And  = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

endpackage

// File: rtl/riscv_femto_alu.sv
// Combinational ALU and branch comparator for riscv_femto.
module riscv_femto_alu
  import riscv_femto_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        is_reg_op,
  output logic [31:0] result,
  output logic        taken
);

  logic [32:0] diff;
  logic        eq;
  logic        ltu;
  logic        lt;
  logic [4:0]  shamt;

  assign diff  = {1'b0, a} - {1'b0, b};
  assign eq    = (a == b);
  assign ltu   = diff[32];
  // With equal signs the unsigned order matches the signed order.
  assign lt    = (a[31] ^ b[31]) ? a[31] : ltu;
  assign shamt = b[4:0];

  always_comb begin
    result = a + b;
    case (funct3)
      F3Add:   result = (is_reg_op && funct7_5) ? diff[31:0] : a + b;
      F3Sll:   result = a << shamt;
      F3Slt:   result = {31'd0, lt};
      F3Sltu:  result = {31'd0, ltu};
      F3Xor:   result = a ^ b;
      F3Sr:    result = funct7_5 ? $unsigned($signed(a) >>> shamt) : a >> shamt;
      F3Or:    result = a | b;
      F3And:   result = a & b;
      default: result = a + b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3Beq:   taken = eq;
      F3Bne:   taken = !eq;
      F3Blt:   taken = lt;
      F3Bge:   taken = !lt;
      F3Bltu:  taken = ltu;
      F3Bgeu:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_femto.sv
// Multi-cycle RV32I core on a single shared memory port.
// Define RISCV_FEMTO_EBREAK_EN to make SYSTEM opcodes halt the core.
module riscv_femto
  import riscv_femto_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] memIn,
  output logic [31:0] memAddr,
  output logic        memRead,
  output logic [3:0]  memWstrb,
  output logic [31:0] memWrite
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q;
  logic [31:0] rs1_q, rs2_q;
  logic [31:0] regFile [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1_idx, rs2_idx;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, ls_addr, alu_b, alu_result, load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        taken;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign opcode  = instr_q[6:0];
  assign rd      = instr_q[11:7];
  assign funct3  = instr_q[14:12];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];

  assign imm_i = {{21{instr_q[31]}}, instr_q[30:20]};
  assign imm_s = {{21{instr_q[31]}}, instr_q[30:25], instr_q[11:7]};
  assign imm_b = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'd0};
  assign imm_j = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  assign pc_plus4 = pc_q + 32'd4;
  assign ls_addr  = rs1_q + ((opcode == OpStore) ? imm_s : imm_i);
  assign alu_b    = ((opcode == OpAluReg) || (opcode == OpBranch)) ? rs2_q : imm_i;

  riscv_femto_alu u_alu (
    .a        (rs1_q),
    .b        (alu_b),
    .funct3   (funct3),
    .funct7_5 (instr_q[30]),
    .is_reg_op(opcode == OpAluReg),
    .result   (alu_result),
    .taken    (taken)
  );

  always_comb begin
    case (ls_addr[1:0])
      2'd0:    load_byte = memIn[7:0];
      2'd1:    load_byte = memIn[15:8];
      2'd2:    load_byte = memIn[23:16];
      default: load_byte = memIn[31:24];
    endcase
    load_half = ls_addr[1] ? memIn[31:16] : memIn[15:0];
    case (funct3)
      F3Byte:  load_data = {{24{load_byte[7]}}, load_byte};
      F3Half:  load_data = {{16{load_half[15]}}, load_half};
      F3ByteU: load_data = {24'd0, load_byte};
      F3HalfU: load_data = {16'd0, load_half};
      default: load_data = memIn;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rf_we    = 1'b0;
    rf_wdata = alu_result;
    memAddr  = pc_q;
    memRead  = 1'b0;
    memWstrb = 4'd0;
    memWrite = 32'd0;
    case (state_q)
      StFetchInstr: begin
        // Gated so the strobe drops the instant reset asserts.
        memRead = rstn;
        state_d = StWaitInstr;
      end
      StWaitInstr: state_d = StFetchRegs;
      StFetchRegs: state_d = StExecute;
      StExecute: begin
        state_d = StFetchInstr;
        pc_d    = pc_plus4;
        case (opcode)
          OpLui:    begin rf_we = 1'b1; rf_wdata = imm_u; end
          OpAuipc:  begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
          OpJal:    begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = pc_q + imm_j; end
          OpJalr: begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
            pc_d     = (rs1_q + imm_i) & ~32'd1;
          end
          OpBranch: if (taken) pc_d = pc_q + imm_b;
          OpAluImm, OpAluReg: rf_we = 1'b1;
          OpLoad:   state_d = StLoad;
          OpStore:  state_d = StStore;
`ifdef RISCV_FEMTO_EBREAK_EN
          OpSystem: begin state_d = StHalt; pc_d = pc_q; end
`endif
          default: ;
        endcase
      end
      StLoad: begin
        memAddr = ls_addr;
        memRead = 1'b1;
        state_d = StWaitData;
      end
      StWaitData: begin
        memAddr  = ls_addr;
        rf_we    = 1'b1;
        rf_wdata = load_data;
        state_d  = StFetchInstr;
      end
      StStore: begin
        memAddr = ls_addr;
        state_d = StFetchInstr;
        case (funct3)
          F3Byte: begin
            memWstrb = 4'b0001 << ls_addr[1:0];
            memWrite = {4{rs2_q[7:0]}};
          end
          F3Half: begin
            memWstrb = 4'b0011 << {ls_addr[1], 1'b0};
            memWrite = {2{rs2_q[15:0]}};
          end
          default: begin
            memWstrb = 4'b1111;
            memWrite = rs2_q;
          end
        endcase
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetchInstr;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StFetchInstr;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == StWaitInstr) instr_q <= memIn;
      if (state_q == StFetchRegs) begin
        rs1_q <= (rs1_idx == 5'd0) ? 32'd0 : regFile[rs1_idx];
        rs2_q <= (rs2_idx == 5'd0) ? 32'd0 : regFile[rs2_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && (rd != 5'd0)) regFile[rd] <= rf_wdata;
  end

endmodule

// File: tb/tb_riscv_femto.sv
// Directed programs for riscv_femto with a 1-cycle RAM and LED/UART I/O model.
module tb_riscv_femto;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] memIn = 32'd0;
  logic [31:0] memAddr, memWrite;
  logic        memRead;
  logic [3:0]  memWstrb;

  always #5 clk = ~clk;

  riscv_femto dut (
    .clk     (clk),
    .rstn    (rstn),
    .memIn   (memIn),
    .memAddr (memAddr),
    .memRead (memRead),
    .memWstrb(memWstrb),
    .memWrite(memWrite)
  );

  logic [31:0] ram [64];
  logic [31:0] img [64];
  logic        ld_en = 1'b0;
  int          cyc, run_start, uart_polls, tx_count, both_cnt, rd_consec;
  int          first_rd [64];
  int          rd_cnt [64];
  logic        prev_rd = 1'b0;
  logic [7:0]  tx_char, leds;
  logic [3:0]  led_strb, sh_strb;
  logic [31:0] led_wdata;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_rd <= memRead;
    if (memRead && prev_rd) rd_consec <= rd_consec + 1;
    if (memRead && (memWstrb != 4'd0)) both_cnt <= both_cnt + 1;
    if (ld_en) begin
      for (int i = 0; i < 64; i++) ram[i] <= img[i];
      uart_polls <= 0;
      tx_count   <= 0;
      tx_char    <= 8'd0;
      leds       <= 8'd0;
      led_strb   <= 4'd0;
      sh_strb    <= 4'd0;
      led_wdata  <= 32'd0;
    end else begin
      if (memRead) begin
        if (memAddr[22]) begin
          memIn <= (memAddr[4:2] == 3'd4 && uart_polls >= 3) ? 32'h0000_0200 : 32'd0;
          if (memAddr[4:2] == 3'd4) uart_polls <= uart_polls + 1;
        end else begin
          memIn <= ram[memAddr[7:2]];
          if (first_rd[memAddr[7:2]] < run_start) first_rd[memAddr[7:2]] <= cyc;
          rd_cnt[memAddr[7:2]] <= rd_cnt[memAddr[7:2]] + 1;
        end
      end
      if (memWstrb != 4'd0) begin
        if (memAddr[22]) begin
          if (memAddr[4:2] == 3'd1) begin
            leds      <= memWrite[7:0];
            led_strb  <= memWstrb;
            led_wdata <= memWrite;
          end else if (memAddr[4:2] == 3'd2) begin
            tx_count <= tx_count + 1;
            tx_char  <= memWrite[7:0];
          end
        end else begin
          for (int l = 0; l < 4; l++)
            if (memWstrb[l]) ram[memAddr[7:2]][8*l +: 8] <= memWrite[8*l +: 8];
          if (memAddr[7:2] == 6'd17) sh_strb <= memWstrb;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rd, input int f3, input int rs1,
                                        input int imm);
    logic [31:0] o, d, f, s, i;
    o = op; d = rd; f = f3; s = rs1; i = imm;
    return {i[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int f3, input int rs1, input int rs2,
                                        input int f7);
    logic [31:0] d, f, s, t, g;
    d = rd; f = f3; s = rs1; t = rs2; g = f7;
    return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] f, s, t, i;
    f = f3; s = rs1; t = rs2; i = imm;
    return {i[11:5], t[4:0], s[4:0], f[2:0], i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] f, s, t, i;
    f = f3; s = rs1; t = rs2; i = imm;
    return {i[12], i[10:5], t[4:0], s[4:0], f[2:0], i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] d, i;
    d = rd; i = imm;
    return {i[20], i[10:1], i[11], i[19:12], d[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input int op, input int rd, input int imm);
    logic [31:0] o, d, i;
    o = op; d = rd; i = imm;
    return {i[19:0], d[4:0], o[6:0]};
  endfunction

  task automatic load_prog();
    rstn  = 1'b0;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
    run_start = cyc;
  endtask

  task automatic release_and_run(input int cycles);
    rstn = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  int snap_a, snap_b, snap_c, waited, reads;

  initial begin
    // Reset state with outputs observed while rstn is low.
    #1;
    check("rst_memRead", {31'd0, memRead}, 32'd0);
    check("rst_memWstrb", {28'd0, memWstrb}, 32'd0);
    check("rst_memAddr", memAddr, 32'd0);
    check("rst_memWrite", memWrite, 32'd0);

    // Arithmetic, loads and stores.
    for (int i = 0; i < 64; i++) img[i] = 32'd0;
    img[0]  = enc_i(32'h13, 1, 0, 0, 5);
    img[1]  = enc_i(32'h13, 2, 0, 0, -3);
    img[2]  = enc_r(3, 0, 1, 2, 0);
    img[3]  = enc_r(4, 0, 2, 1, 32'h20);
    img[4]  = enc_i(32'h13, 5, 5, 2, 32'h401);
    img[5]  = enc_i(32'h13, 0, 0, 0, 7);
    img[6]  = enc_i(32'h13, 18, 0, 0, 9);
    img[7]  = enc_i(32'h03, 6, 0, 0, 64);
    img[8]  = enc_i(32'h03, 9, 4, 0, 65);
    img[9]  = enc_i(32'h03, 10, 1, 0, 66);
    img[10] = enc_i(32'h03, 11, 2, 0, 64);
    img[11] = enc_i(32'h13, 7, 0, 0, 32'hAB);
    img[12] = enc_u(32'h37, 12, 32'h400);
    img[13] = enc_s(0, 12, 7, 4);
    img[14] = enc_s(1, 0, 11, 70);
    img[15] = enc_j(0, 0);
    img[16] = 32'h1234_8280;
    load_prog();
    release_and_run(120);
    check("x3_add", dut.regFile[3], 32'h0000_0002);
    check("x4_sub", dut.regFile[4], 32'hFFFF_FFF8);
    check("x5_srai", dut.regFile[5], 32'hFFFF_FFFE);
    check("x18_x0_reads_zero", dut.regFile[18], 32'd9);
    check("x6_lb", dut.regFile[6], 32'hFFFF_FF80);
    check("x9_lbu", dut.regFile[9], 32'h0000_0082);
    check("x10_lh", dut.regFile[10], 32'h0000_1234);
    check("x11_lw", dut.regFile[11], 32'h1234_8280);
    check("led_strb", {28'd0, led_strb}, 32'h1);
    check("led_wdata_b0", {24'd0, led_wdata[7:0]}, 32'hAB);
    check("leds", {24'd0, leds}, 32'hAB);
    check("sh_strb", {28'd0, sh_strb}, 32'hC);
    check("sh_ram", ram[17], 32'h8280_0000);
    check("cpi_alu", first_rd[1] - first_rd[0], 32'd4);
    check("cpi_load", first_rd[8] - first_rd[7], 32'd6);
    check("cpi_store", first_rd[14] - first_rd[13], 32'd5);

    // Control flow: JAL, JALR with odd target, BNE countdown.
    for (int i = 0; i < 64; i++) img[i] = 32'd0;
    img[0]  = enc_i(32'h13, 14, 0, 0, 0);
    img[1]  = enc_i(32'h13, 8, 0, 0, 3);
    img[2]  = enc_i(32'h13, 15, 0, 0, 32'h21);
    img[3]  = enc_i(32'h13, 16, 0, 0, 0);
    img[4]  = enc_j(1, 8);
    img[5]  = enc_i(32'h13, 16, 0, 0, 99);
    img[6]  = enc_i(32'h67, 17, 0, 15, 0);
    img[7]  = enc_i(32'h13, 16, 0, 0, 99);
    img[8]  = enc_i(32'h13, 14, 0, 14, 1);
    img[9]  = enc_i(32'h13, 8, 0, 8, -1);
    img[10] = enc_b(1, 8, 0, -8);
    img[11] = enc_j(0, 0);
    snap_a = rd_cnt[8]; snap_b = rd_cnt[5]; snap_c = rd_cnt[7];
    load_prog();
    release_and_run(120);
    check("jal_ra", dut.regFile[1], 32'h14);
    check("jalr_link", dut.regFile[17], 32'h1C);
    check("skipped_instrs", dut.regFile[16], 32'd0);
    check("loop_count", dut.regFile[14], 32'd3);
    check("loop_x8", dut.regFile[8], 32'd0);
    check("loop_body_fetches", rd_cnt[8] - snap_a, 32'd3);
    check("fetch_0x14_skipped", (rd_cnt[5] - snap_b) + (rd_cnt[7] - snap_c), 32'd0);

    // UART polling then one character out.
    for (int i = 0; i < 64; i++) img[i] = 32'd0;
    img[0] = enc_u(32'h37, 12, 32'h400);
    img[1] = enc_i(32'h03, 5, 2, 12, 16);
    img[2] = enc_i(32'h13, 5, 5, 5, 9);
    img[3] = enc_i(32'h13, 5, 7, 5, 1);
    img[4] = enc_b(0, 5, 0, -12);
    img[5] = enc_i(32'h13, 7, 0, 0, 32'h48);
    img[6] = enc_s(0, 12, 7, 8);
    img[7] = enc_j(0, 0);
    load_prog();
    release_and_run(200);
    check("uart_polls", uart_polls, 32'd4);
    check("uart_tx_count", tx_count, 32'd1);
    check("uart_tx_char", {24'd0, tx_char}, 32'h48);

    // Reset asserted in the middle of the UART store.
    load_prog();
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("first_fetch_read", {31'd0, memRead}, 32'd1);
    check("first_fetch_addr", memAddr, 32'd0);
    waited = 0;
    while (memWstrb == 4'd0 && waited < 300) begin
      @(posedge clk);
      #1 waited++;
    end
    check("store_reached", {28'd0, memWstrb}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("midstore_wstrb", {28'd0, memWstrb}, 32'd0);
    check("midstore_read", {31'd0, memRead}, 32'd0);
    check("midstore_addr", memAddr, 32'd0);
    check("midstore_wdata", memWrite, 32'd0);
    @(posedge clk);
    #1;
    check("midstore_no_tx", tx_count, 32'd0);
    check("midstore_pc", dut.pc_q, 32'd0);

    // SYSTEM opcode at 0x20.
    for (int i = 0; i < 64; i++) img[i] = 32'h0000_0013;
    img[0]  = enc_i(32'h13, 20, 0, 0, 0);
    img[8]  = 32'h0010_0073;
    img[9]  = enc_i(32'h13, 20, 0, 0, 1);
    img[10] = enc_j(0, 0);
    snap_a = rd_cnt[9];
    load_prog();
    release_and_run(80);
`ifdef RISCV_FEMTO_EBREAK_EN
    check("halt_no_next", dut.regFile[20], 32'd0);
    check("halt_no_fetch", rd_cnt[9] - snap_a, 32'd0);
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (memRead || memWstrb != 4'd0) reads++;
    end
    check("halt_bus_idle", reads, 32'd0);
    check("halt_pc", memAddr, 32'h20);
`else
    check("system_nop", dut.regFile[20], 32'd1);
    check("system_next_fetch", (rd_cnt[9] - snap_a) > 0 ? 32'd1 : 32'd0, 32'd1);
    reads = 0;
`endif

    check("no_rd_wr_overlap", both_cnt, 32'd0);
    check("no_back_to_back_reads", rd_consec, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
